stream_arbiter: RTL
===================

STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 Parameter N, default 4, SHALL set the number of AXI-Stream input ports (legal range 2..16).
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the t_data width in bits (a multiple of 8); t_strb and t_keep widths SHALL be DATA_WIDTH/8.
REQ-003 Parameters ID_WIDTH, DEST_WIDTH and USER_WIDTH, default 1 each, SHALL set the t_id, t_dest and t_user widths.
REQ-004 Local SEL_WIDTH SHALL equal max(1, clog2(N)).
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_t_valid / in_t_ready  in / out  N each  per-port handshake; bit i belongs to port i.
REQ-008 in_t_id, in_t_dest, in_t_data, in_t_strb, in_t_keep, in_t_last, in_t_user  in  N x field width (packed, port i in slice i)  per-port beat fields.
REQ-009 out_t_valid / out_t_ready  out / in  1 each  output handshake.
REQ-010 out_t_id, out_t_dest, out_t_data, out_t_strb, out_t_keep, out_t_last, out_t_user  out  field width  output beat fields.
REQ-011 out_src  out  SEL_WIDTH  index of the input port that supplied the current output beat.

Function
REQ-012 The block SHALL merge N streams onto one output with round-robin, packet-atomic arbitration: once a port wins, its beats alone pass until a beat with t_last=1 is transferred.
REQ-013 State SHALL be IDLE (no owner) or LOCKED(owner); a pointer ptr (SEL_WIDTH bits) SHALL hold the highest-priority index for the next arbitration.
REQ-014 The output SHALL be a one-entry register; slot_free = !out_t_valid || out_t_ready.
REQ-015 In IDLE, winner SHALL be the first index i with in_t_valid[i]=1, searching ptr, ptr+1, ..., wrapping modulo N (not modulo 2^SEL_WIDTH).
REQ-016 in_t_ready[i] SHALL be 1 only when i is the current grant (winner in IDLE, owner in LOCKED) and slot_free=1; all other ready bits SHALL be 0.
REQ-017 in_t_ready SHALL NOT depend on the granted port's in_t_valid beyond winner selection (no valid->ready loop on the same port).
REQ-018 On an input transfer, the beat fields and the grant index SHALL be registered into the output slot and out_t_valid set to 1 on the next edge (latency 1 cycle).
REQ-019 If out_t_ready=1 and no input transfer occurs, out_t_valid SHALL clear on the next edge; output fields SHALL hold while out_t_valid=1 and out_t_ready=0.
REQ-020 Simultaneous output drain and input transfer SHALL sustain one beat per cycle.
REQ-021 IDLE transfer with t_last=0 SHALL enter LOCKED(winner); with t_last=1 SHALL stay IDLE.
REQ-022 LOCKED transfer with t_last=1 SHALL return to IDLE; otherwise stay LOCKED.
REQ-023 On every transfer with t_last=1, ptr SHALL become (grant+1) mod N; ptr SHALL not change otherwise.
REQ-024 In LOCKED, owner deasserting in_t_valid mid-packet SHALL NOT release the lock; other ports SHALL wait.
REQ-025 A port asserting in_t_valid SHALL be granted within N-1 packets from other ports (starvation freedom).

Reset
REQ-026 While rst=1: state=IDLE, ptr=0, out_t_valid=0, out_src=0, out_t_last=0, all other output fields 0, in_t_ready=0.
REQ-027 Reset asserted mid-packet SHALL discard the held beat and lock; arbitration after reset SHALL start at port 0.

Verification
V1 N=4, reset, then ports 0..3 each send one-beat packet (t_last=1) every cycle, out_t_ready=1 -> out_src sequence 0,1,2,3,0,..., one beat/cycle, first out_t_valid one cycle after first accept.
V2 Port 1 sends 3-beat packet, port 2 valid throughout -> out_src 1,1,1 then 2; in_t_ready[2]=0 until port 1's t_last transfers.
V3 Port 0 mid-packet drops valid for 2 cycles while port 3 valid -> no port-3 beat emitted until port 0's t_last; out_t_valid low during gap.
V4 out_t_ready held 0 for 5 cycles with data pending -> out fields stable, all in_t_ready=0, no beat lost or duplicated on resume.
V5 N=3, ptr=2, ports 0 and 2 valid -> port 2 granted, then port 0 (wrap modulo 3, index 3 never selected).
V6 rst pulsed during LOCKED(2) with beat held -> next cycle out_t_valid=0, ptr=0; port 0 and 2 valid -> port 0 wins.

Source files
------------

// File: rtl/stream_arbiter.sv
// Round-robin, packet-atomic AXI-Stream merger: N input streams share one
// registered output slot; a winning port keeps the grant until its t_last beat.
module stream_arbiter #(
  parameter  int N          = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int ID_WIDTH   = 1,
  parameter  int DEST_WIDTH = 1,
  parameter  int USER_WIDTH = 1,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8,
  localparam int SEL_WIDTH  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic [N-1:0]               in_t_valid,
  output logic [N-1:0]               in_t_ready,
  input  logic [N*ID_WIDTH-1:0]      in_t_id,
  input  logic [N*DEST_WIDTH-1:0]    in_t_dest,
  input  logic [N*DATA_WIDTH-1:0]    in_t_data,
  input  logic [N*KEEP_WIDTH-1:0]    in_t_strb,
  input  logic [N*KEEP_WIDTH-1:0]    in_t_keep,
  input  logic [N-1:0]               in_t_last,
  input  logic [N*USER_WIDTH-1:0]    in_t_user,

  output logic                       out_t_valid,
  input  logic                       out_t_ready,
  output logic [ID_WIDTH-1:0]        out_t_id,
  output logic [DEST_WIDTH-1:0]      out_t_dest,
  output logic [DATA_WIDTH-1:0]      out_t_data,
  output logic [KEEP_WIDTH-1:0]      out_t_strb,
  output logic [KEEP_WIDTH-1:0]      out_t_keep,
  output logic                       out_t_last,
  output logic [USER_WIDTH-1:0]      out_t_user,
  output logic [SEL_WIDTH-1:0]       out_src
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [SEL_WIDTH-1:0] owner_q, owner_d;
  logic [SEL_WIDTH-1:0] ptr_q,   ptr_d;

  logic                  valid_q;
  logic [SEL_WIDTH-1:0]  src_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [DEST_WIDTH-1:0] dest_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [KEEP_WIDTH-1:0] strb_q;
  logic [KEEP_WIDTH-1:0] keep_q;
  logic                  last_q;
  logic [USER_WIDTH-1:0] user_q;

  logic                  win_found;
  logic [SEL_WIDTH-1:0]  winner;
  logic [SEL_WIDTH-1:0]  grant;
  logic                  slot_free;
  logic                  grant_ok;
  logic                  xfer;

  logic                  sel_valid;
  logic [ID_WIDTH-1:0]   sel_id;
  logic [DEST_WIDTH-1:0] sel_dest;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_strb;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic                  sel_last;
  logic [USER_WIDTH-1:0] sel_user;

  // Ports at or above ptr outrank the lower ones, which gives the modulo-N wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    win_found = 1'b0;
    winner    = '0;
    for (int i = 0; i < N; i++) begin
      if (!win_found && in_t_valid[i] && (SEL_WIDTH'(i) >= ptr_q)) begin
        win_found = 1'b1;
        winner    = SEL_WIDTH'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!win_found && in_t_valid[i]) begin
        win_found = 1'b1;
        winner    = SEL_WIDTH'(i);
      end
    end
  end

  assign slot_free = !valid_q || out_t_ready;
  assign grant     = (state_q == ST_LOCKED) ? owner_q : winner;
  // A locked owner is offered ready whether or not it is presenting a beat.
  assign grant_ok  = !rst && slot_free && ((state_q == ST_LOCKED) || win_found);

  always_comb begin
    in_t_ready = '0;
    sel_valid  = 1'b0;
    sel_id     = '0;
    sel_dest   = '0;
    sel_data   = '0;
    sel_strb   = '0;
    sel_keep   = '0;
    sel_last   = 1'b0;
    sel_user   = '0;
    for (int i = 0; i < N; i++) begin
      if (SEL_WIDTH'(i) == grant) begin
        in_t_ready[i] = grant_ok;
        sel_valid     = in_t_valid[i];
        sel_id        = in_t_id[i*ID_WIDTH +: ID_WIDTH];
        sel_dest      = in_t_dest[i*DEST_WIDTH +: DEST_WIDTH];
        sel_data      = in_t_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_strb      = in_t_strb[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_keep      = in_t_keep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_last      = in_t_last[i];
        sel_user      = in_t_user[i*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  assign xfer = sel_valid && grant_ok;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      if (sel_last) begin
        state_d = ST_IDLE;
        ptr_d   = (grant == SEL_WIDTH'(N - 1)) ? '0 : grant + 1'b1;
      end else begin
        state_d = ST_LOCKED;
        owner_d = grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      // NOTE: the output datapath is reset too because the beat fields must read zero after reset.
      src_q   <= '0;
      id_q    <= '0;
      dest_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      if (xfer) begin
        valid_q <= 1'b1;
        src_q   <= grant;
        id_q    <= sel_id;
        dest_q  <= sel_dest;
        data_q  <= sel_data;
        strb_q  <= sel_strb;
        keep_q  <= sel_keep;
        last_q  <= sel_last;
        user_q  <= sel_user;
      end else if (out_t_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_t_valid = valid_q;
  assign out_src     = src_q;
  assign out_t_id    = id_q;
  assign out_t_dest  = dest_q;
  assign out_t_data  = data_q;
  assign out_t_strb  = strb_q;
  assign out_t_keep  = keep_q;
  assign out_t_last  = last_q;
  assign out_t_user  = user_q;

endmodule
